axi_burst_ram: RTL and testbench



---
 rtl/axi_burst_ram.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 slave memory endpoint with its own storage array.
// Supports FIXED/INCR/WRAP bursts, IDs, per-beat SLVERR/DECERR and full backpressure.
//
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   aw_* / w_* / b_*                 write address, write data and write response channels
//   ar_* / r_*                       read address and read data channels
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The source holds valid and its payload stable until that edge. Every ready/valid
// output here is a register, so no input reaches any output combinationally.
//
// Read and write each run their own FSM, so neither channel ever stalls the other.
// Reads sample the array before the same-edge write lands (read-before-write).
module axi_burst_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 65536
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [ID_W-1:0]     r_id,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_last
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE    = 3'(OFFS);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFFS);
    endfunction

    // WRAP keeps the address inside a (len+1)*B window aligned to its own size.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] b, inc, wmask;
        b     = ADDR_W'(1) << size;
        inc   = a + b;
        wmask = (ADDR_W'(len) + ADDR_W'(1)) * b - ADDR_W'(1);
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~wmask) | (inc & wmask);
            default:     return inc;
        endcase
    endfunction

    // DECERR wins over SLVERR so the accumulated write response keeps the highest code.
    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] a,
            input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] hi;
        hi = a >> (OFFS + IDX_W);
        if (hi != '0) return RESP_DECERR;
        if (size > MAX_SIZE || burst == BURST_RSVD) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // ---------------- write path ----------------
    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic [8:0]        w_cnt_q, w_cnt_d;      // 9 bits so len=255 cannot wrap back into range
    logic [1:0]        w_err_q, w_err_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [1:0]        w_beat_resp;
    logic [1:0]        w_err_new;

    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        aw_ready_d  = aw_ready_q;
        w_ready_d   = w_ready_q;
        b_valid_d   = b_valid_q;
        b_id_d      = b_id_q;
        b_resp_d    = b_resp_q;
        mem_we      = 1'b0;
        mem_widx    = word_idx(aw_addr_q);
        w_beat_resp = beat_resp(aw_addr_q, aw_size_q, aw_burst_q);
        w_err_new   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid && aw_ready_q) begin
                    aw_id_d    = aw_id;
                    aw_addr_d  = aw_addr;
                    aw_len_d   = aw_len;
                    aw_size_d  = aw_size;
                    aw_burst_d = aw_burst;
                    w_cnt_d    = '0;
                    w_err_d    = RESP_OKAY;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid && w_ready_q) begin
                    // Beats past len are accepted but touch neither memory nor status.
                    if (w_cnt_q <= {1'b0, aw_len_q}) begin
                        mem_we    = (w_beat_resp == RESP_OKAY) && !reset;
                        w_err_new = (w_beat_resp > w_err_q) ? w_beat_resp : w_err_q;
                        w_err_d   = w_err_new;
                        aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                        w_cnt_d   = w_cnt_q + 9'd1;
                    end
                    if (w_last) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_id_d    = aw_id_q;
                        b_resp_d  = (w_cnt_q != {1'b0, aw_len_q}) ? RESP_SLVERR : w_err_new;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_valid_q && b_ready) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: begin
                w_state_d  = W_IDLE;
                aw_ready_d = 1'b1;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
        end
    end

    // Storage is never reset; contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem[mem_widx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              ar_ready_q, ar_ready_d;
    logic              r_valid_q, r_valid_d;
    logic              r_last_q, r_last_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic [1:0]        rd_resp;
    logic              rd_load;

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_id_d     = r_id_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        rd_addr    = ar_addr_q;
        rd_size    = ar_size_q;
        rd_burst   = ar_burst_q;
        rd_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid && ar_ready_q) begin
                    ar_addr_d  = ar_addr;
                    ar_len_d   = ar_len;
                    ar_size_d  = ar_size;
                    ar_burst_d = ar_burst;
                    rd_addr    = ar_addr;
                    rd_size    = ar_size;
                    rd_burst   = ar_burst;
                    rd_load    = 1'b1;
                    r_cnt_d    = '0;
                    r_last_d   = (ar_len == 8'd0);
                    r_id_d     = ar_id;
                    r_valid_d  = 1'b1;
                    ar_ready_d = 1'b0;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                // Without a fire every r_* register simply holds.
                if (r_valid_q && r_ready) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        rd_addr   = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
                        ar_addr_d = rd_addr;
                        rd_load   = 1'b1;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_last_d  = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: begin
                r_state_d  = R_IDLE;
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
                r_last_d   = 1'b0;
            end
        endcase
        rd_resp = beat_resp(rd_addr, rd_size, rd_burst);
        if (rd_load) begin
            r_resp_d = rd_resp;
            r_data_d = (rd_resp == RESP_OKAY) ? mem[word_idx(rd_addr)] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_id     = b_id_q;
    assign b_resp   = b_resp_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_id     = r_id_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Testbench for axi_burst_ram (DATA_W=64, DEPTH=65536).
// Inputs change and outputs are sampled on the falling edge of clock.
module tb_axi_burst_ram;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        aw_valid = 1'b0, aw_ready;
    logic [3:0]  aw_id = '0;
    logic [31:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        b_valid, b_ready = 1'b0;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [3:0]  ar_id = '0;
    logic [31:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    axi_burst_ram #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .DEPTH(65536)) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];
    logic [63:0] wdata_a[16];
    logic [7:0]  wstrb_a[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- driver tasks (enter and leave on a falling edge) ----------------
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int last_beat, input int b_hold, output logic [1:0] resp);
        int tmo;
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        tmo = 0;
        while (!aw_ready && tmo < 50) begin @(negedge clock); tmo++; end
        if (tmo >= 50) check("aw_ready_timeout", 0, 1);
        @(posedge clock); @(negedge clock);
        aw_valid = 1'b0;
        check("w_ready_after_aw", w_ready, 1);
        for (int i = 0; i <= last_beat; i++) begin
            w_valid = 1'b1; w_data = wdata_a[i]; w_strb = wstrb_a[i]; w_last = (i == last_beat);
            tmo = 0;
            while (!w_ready && tmo < 50) begin @(negedge clock); tmo++; end
            if (tmo >= 50) check("w_ready_timeout", 0, 1);
            @(posedge clock); @(negedge clock);
        end
        w_valid = 1'b0; w_last = 1'b0;
        check("b_valid_after_last", b_valid, 1);
        for (int i = 0; i < b_hold; i++) begin
            @(posedge clock); @(negedge clock);
            check("b_valid_held", b_valid, 1);
            check("b_id_held", b_id, id);
        end
        b_ready = 1'b1;
        check("b_id", b_id, id);
        resp = b_resp;
        @(posedge clock); @(negedge clock);
        b_ready = 1'b0;
        check("b_valid_after_b", b_valid, 0);
        check("aw_ready_after_b", aw_ready, 1);
    endtask

    // Expected beats must already be queued. rdy_pat[k % 4] drives r_ready on cycle k.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [3:0] rdy_pat);
        int tmo, beat, cyc;
        logic stalled, rdy;
        logic [63:0] held_data;
        logic held_last;
        logic [63:0] e;
        logic [1:0] er;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        tmo = 0;
        while (!ar_ready && tmo < 50) begin @(negedge clock); tmo++; end
        if (tmo >= 50) check("ar_ready_timeout", 0, 1);
        @(posedge clock); @(negedge clock);
        ar_valid = 1'b0;
        check("ar_ready_busy", ar_ready, 0);
        beat = 0; cyc = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
        while (beat <= int'(len) && cyc < 300) begin
            check("r_valid_in_burst", r_valid, 1);
            if (stalled) begin
                check("r_data_stable", r_data, held_data);
                check("r_last_stable", r_last, held_last);
            end
            rdy = rdy_pat[cyc % 4];
            r_ready = rdy;
            if (r_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    er = exp_resp_q.pop_front();
                    check("r_data", r_data, e);
                    check("r_resp", r_resp, er);
                end
                check("r_last", r_last, (beat == int'(len)));
                check("r_id", r_id, id);
                beat++;
            end
            stalled = r_valid && !rdy;
            held_data = r_data; held_last = r_last;
            @(posedge clock); @(negedge clock);
            cyc++;
        end
        r_ready = 1'b0;
        if (cyc >= 300) check("read_timeout", 0, 1);
        check("r_valid_after_last", r_valid, 0);
        check("ar_ready_after_last", ar_ready, 1);
    endtask

    // ---------------- single-beat vector table ----------------
    typedef struct {
        logic [3:0]  id;
        logic [31:0] waddr;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [63:0] wdata;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [2:0]  rsize;
        logic [1:0]  rburst;
        logic [1:0]  exp_rresp;
        logic [63:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [1:0] resp;
        vecs[0] = '{4'd1, 32'h0,     3'd3, 2'd1, 64'h0123456789ABCDEF, 2'd0, 32'h0,     3'd3, 2'd1, 2'd0, 64'h0123456789ABCDEF};
        vecs[1] = '{4'd2, 32'h80000, 3'd3, 2'd1, 64'hDEADBEEFDEADBEEF, 2'd3, 32'h0,     3'd3, 2'd1, 2'd0, 64'h0123456789ABCDEF};
        vecs[2] = '{4'd3, 32'h0,     3'd4, 2'd1, 64'hBAD0BAD0BAD0BAD0, 2'd2, 32'h0,     3'd3, 2'd1, 2'd0, 64'h0123456789ABCDEF};
        vecs[3] = '{4'd4, 32'h0,     3'd3, 2'd3, 64'hBAD1BAD1BAD1BAD1, 2'd2, 32'h0,     3'd3, 2'd1, 2'd0, 64'h0123456789ABCDEF};
        vecs[4] = '{4'd5, 32'h8,     3'd3, 2'd0, 64'h55AA55AA55AA55AA, 2'd0, 32'h8,     3'd4, 2'd1, 2'd2, 64'h0};
        vecs[5] = '{4'd6, 32'h10,    3'd3, 2'd1, 64'h0F0F0F0F0F0F0F0F, 2'd0, 32'h80000, 3'd3, 2'd1, 2'd3, 64'h0};
        vecs[6] = '{4'd7, 32'h7FFF8, 3'd3, 2'd1, 64'hCAFEF00DCAFEF00D, 2'd0, 32'h7FFF8, 3'd3, 2'd1, 2'd0, 64'hCAFEF00DCAFEF00D};
        vecs[7] = '{4'd8, 32'h18,    3'd2, 2'd1, 64'h1122334455667788, 2'd0, 32'h18,    3'd3, 2'd1, 2'd0, 64'h1122334455667788};
        vecs[8] = '{4'd9, 32'h20,    3'd3, 2'd1, 64'h0BADC0DE0BADC0DE, 2'd0, 32'h20,    3'd3, 2'd3, 2'd2, 64'h0};
        vecs[9] = '{4'd10, 32'h28,   3'd3, 2'd2, 64'h2828282828282828, 2'd0, 32'h8,     3'd3, 2'd0, 2'd0, 64'h55AA55AA55AA55AA};

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_aw_ready", aw_ready, 1);
        check("rst_ar_ready", ar_ready, 1);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_b_fields", {b_id, b_resp}, 0);
        check("rst_r_fields", {r_id, r_resp}, 0);
        check("rst_r_data", r_data, 0);

        // Table: single-beat write, then single-beat read
        for (int i = 0; i < 10; i++) begin
            wdata_a[0] = vecs[i].wdata; wstrb_a[0] = 8'hFF;
            write_burst(vecs[i].id, vecs[i].waddr, 8'd0, vecs[i].wsize, vecs[i].wburst, 0, 0, resp);
            check("vec_b_resp", resp, vecs[i].exp_bresp);
            exp_q.push_back(vecs[i].exp_rdata);
            exp_resp_q.push_back(vecs[i].exp_rresp);
            read_burst(vecs[i].id, vecs[i].raddr, 8'd0, vecs[i].rsize, vecs[i].rburst, 4'b1111);
        end

        // INCR write len=3 at 0x100, then INCR read back with r_ready high
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 64'h11 * (i + 1); wstrb_a[i] = 8'hFF; end
        write_burst(4'd3, 32'h100, 8'd3, 3'd3, 2'd1, 3, 0, resp);
        check("incr_b_resp", resp, 0);
        for (int i = 0; i < 4; i++) begin exp_q.push_back(64'h11 * (i + 1)); exp_resp_q.push_back(2'd0); end
        read_burst(4'd12, 32'h100, 8'd3, 3'd3, 2'd1, 4'b1111);

        // WRAP read len=3 from 0x118: 0x118, 0x100, 0x108, 0x110
        exp_q.push_back(64'h44); exp_q.push_back(64'h11); exp_q.push_back(64'h22); exp_q.push_back(64'h33);
        for (int i = 0; i < 4; i++) exp_resp_q.push_back(2'd0);
        read_burst(4'd5, 32'h118, 8'd3, 3'd3, 2'd2, 4'b1111);

        // Backpressure: b_ready low 5 cycles, then len=7 read with r_ready 1,0,0,1
        for (int i = 0; i < 8; i++) begin wdata_a[i] = 64'h1000 + i; wstrb_a[i] = 8'hFF; end
        write_burst(4'd9, 32'h200, 8'd7, 3'd3, 2'd1, 7, 5, resp);
        check("bp_b_resp", resp, 0);
        for (int i = 0; i < 8; i++) begin exp_q.push_back(64'h1000 + i); exp_resp_q.push_back(2'd0); end
        read_burst(4'd7, 32'h200, 8'd7, 3'd3, 2'd1, 4'b1001);

        // Partial strobe
        wdata_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_a[0] = 8'hFF;
        write_burst(4'd1, 32'h300, 8'd0, 3'd3, 2'd1, 0, 0, resp);
        wdata_a[0] = 64'h0; wstrb_a[0] = 8'h0F;
        write_burst(4'd1, 32'h300, 8'd0, 3'd3, 2'd1, 0, 0, resp);
        exp_q.push_back(64'hFFFF_FFFF_0000_0000); exp_resp_q.push_back(2'd0);
        read_burst(4'd1, 32'h300, 8'd0, 3'd3, 2'd1, 4'b1111);

        // len=3 write with w_last on the second beat
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 64'h400 + i; wstrb_a[i] = 8'hFF; end
        write_burst(4'd2, 32'h400, 8'd3, 3'd3, 2'd1, 1, 0, resp);
        check("early_last_b_resp", resp, 2);

        // Same-edge read and write to one word: read sees the old value
        wdata_a[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrb_a[0] = 8'hFF;
        write_burst(4'd4, 32'h500, 8'd0, 3'd3, 2'd1, 0, 0, resp);
        aw_valid = 1'b1; aw_id = 4'd5; aw_addr = 32'h500; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'd1;
        @(posedge clock); @(negedge clock);
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 64'hBBBB_BBBB_BBBB_BBBB; w_strb = 8'hFF; w_last = 1'b1;
        ar_valid = 1'b1; ar_id = 4'd6; ar_addr = 32'h500; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'd1;
        check("rbw_w_ready", w_ready, 1);
        check("rbw_ar_ready", ar_ready, 1);
        r_ready = 1'b1; b_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
        check("rbw_r_valid", r_valid, 1);
        check("rbw_old_data", r_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check("rbw_b_valid", b_valid, 1);
        check("rbw_b_resp", b_resp, 0);
        @(posedge clock); @(negedge clock);
        r_ready = 1'b0; b_ready = 1'b0;
        check("rbw_r_done", r_valid, 0);
        check("rbw_b_done", b_valid, 0);
        exp_q.push_back(64'hBBBB_BBBB_BBBB_BBBB); exp_resp_q.push_back(2'd0);
        read_burst(4'd6, 32'h500, 8'd0, 3'd3, 2'd1, 4'b1111);

        // Reset in the middle of a read burst and a write burst
        ar_valid = 1'b1; ar_id = 4'd8; ar_addr = 32'h200; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'd1;
        aw_valid = 1'b1; aw_id = 4'd8; aw_addr = 32'h600; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'd1;
        @(posedge clock); @(negedge clock);
        ar_valid = 1'b0; aw_valid = 1'b0;
        check("mid_r_valid", r_valid, 1);
        check("mid_w_ready", w_ready, 1);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        check("reset_r_valid", r_valid, 0);
        check("reset_ar_ready", ar_ready, 1);
        check("reset_r_last", r_last, 0);
        check("reset_w_ready", w_ready, 0);
        check("reset_aw_ready", aw_ready, 1);
        exp_q.push_back(64'h11); exp_resp_q.push_back(2'd0);
        read_burst(4'd11, 32'h100, 8'd0, 3'd3, 2'd1, 4'b1111);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
